fifo_sync_prog: RTL and testbench
=================================

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

Interface
REQ-001 Parameter DATAWIDTH, default 8: width of din and dout in bits.
REQ-002 Parameter ADDRESSWIDTH, default 4: pointer width.
REQ-003 Parameter DEPTH, default 1<<ADDRESSWIDTH: number of entries, all usable; any other value is illegal.
REQ-004 Parameter MODE, default 0: 0 = standard read, 1 = first-word-fall-through (FWFT).
REQ-005 Parameter AFULL_THRESH, default DEPTH-2: almost_full asserts when count >= AFULL_THRESH.
REQ-006 Parameter AEMPTY_THRESH, default 2: almost_empty asserts when count <= AEMPTY_THRESH.
REQ-007 Legal range SHALL be 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH-1; illegal values SHALL stop elaboration.
REQ-008 Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of contents.
- write  in  1  write request.
- din  in  DATAWIDTH  write data.
- read  in  1  read request (MODE 1: pop the head word).
- dout  out  DATAWIDTH  read data.
- empty, full  out  1  status flags.
- almost_empty, almost_full  out  1  programmable threshold flags.
- count  out  ADDRESSWIDTH+1  current occupancy, 0..DEPTH.
- overflow, underflow  out  1  one-cycle error pulses.

Function
REQ-009 A write SHALL be accepted iff write && !full && !flush; the word is stored at the write pointer, which then increments modulo DEPTH.
REQ-010 A read SHALL be accepted iff read && !empty && !flush; the read pointer then increments modulo DEPTH.
REQ-011 Flags SHALL be sampled from the registered state at the start of the cycle:
- read && write while full: read accepted, write rejected, count -1.
- read && write while empty: write accepted, read rejected, count +1.
- Otherwise both accepted, count unchanged.
REQ-012 count SHALL be registered and update on the edge of each accepted operation; empty = (count==0), full = (count==DEPTH), and the almost flags SHALL be decoded combinationally from the count register, so every flag reflects an operation one cycle after its edge.
REQ-013 MODE 0: dout SHALL be registered, load mem[read pointer] on an accepted read (valid the cycle after the read edge), and hold otherwise.
REQ-014 MODE 1: dout SHALL equal mem[read pointer] whenever empty==0, valid the cycle after the first write into an empty FIFO; dout is don't-care while empty==1.
REQ-015 overflow SHALL pulse for one cycle after write && full && !flush; underflow SHALL pulse for one cycle after read && empty && !flush. State is otherwise unchanged.
REQ-016 flush SHALL zero both pointers and count on the next edge, with priority over any simultaneous read or write; mem contents are not cleared, and in MODE 0 dout is set to 0.
REQ-017 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated word.

Reset
REQ-018 While reset_n==0, outputs SHALL be: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, dout 0.
REQ-019 Assertion mid-operation SHALL discard all contents immediately, independent of clk; the first accepted operation is on the first rising edge after deassertion.

Structure
REQ-020 Shared package fifo_pkg SHALL hold the constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1 and the clog2 helper function.
REQ-021 Storage SHALL be a sub-module fifo_ram_sc: single-clock simple dual-port inferred RAM, one write port and one asynchronous-read port.
REQ-022 Pointers, count, flags and the MODE-0 output register SHALL live in fifo_sync_prog.

Verification
REQ-023 Bench parameters: DATAWIDTH=8, ADDRESSWIDTH=4.
REQ-024 Fill: 16 writes 0x00..0x0F into an empty FIFO -> full=1, count=16, almost_full from count 14; 17th write -> overflow pulses once, count stays 16.
REQ-025 Drain, MODE 0: 16 reads -> dout 0x00..0x0F, each valid one cycle after its read; empty=1 after the last; extra read -> underflow pulse, dout holds 0x0F.
REQ-026 FWFT: MODE 1, write 0xA5 into an empty FIFO -> next cycle empty=0 and dout=0xA5 with no read; read -> empty=1.
REQ-027 Simultaneous: read+write while full -> count 15, write rejected, overflow pulse; read+write at count 5 -> count 5 and data order preserved.
REQ-028 Wrap, flush and reset: 40 interleaved ops crossing the wrap -> in-order data; flush with write at count 9 -> count 0, empty 1; reset_n low mid-burst -> all REQ-018 values asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram_sc.sv
// Single-clock simple dual-port RAM: one synchronous write port, one asynchronous read port.
module fifo_ram_sc #(
    parameter int DATAWIDTH    = 8,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDRESSWIDTH-1:0] waddr,
    input  logic [DATAWIDTH-1:0]    wdata,
    input  logic [ADDRESSWIDTH-1:0] raddr,
    output logic [DATAWIDTH-1:0]    rdata
);

    logic [DATAWIDTH-1:0] mem [1<<ADDRESSWIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-flags, standard or first-word-fall-through read,
// synchronous flush and overflow/underflow pulses.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH     = 8,
    parameter int ADDRESSWIDTH  = 4,
    parameter int DEPTH         = 1 << ADDRESSWIDTH,
    parameter int MODE          = FIFO_MODE_STD,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  write,
    input  logic [DATAWIDTH-1:0]  din,
    input  logic                  read,
    output logic [DATAWIDTH-1:0]  dout,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDRESSWIDTH:0] count,
    output logic                  overflow,
    output logic                  underflow
);

    if (DEPTH != (1 << ADDRESSWIDTH) || clog2(DEPTH) != ADDRESSWIDTH) begin : g_bad_depth
        $error("fifo_sync_prog: DEPTH must equal 1<<ADDRESSWIDTH");
    end
    if (!(AEMPTY_THRESH >= 1 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH - 1)) begin : g_bad_thresh
        $error("fifo_sync_prog: need 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH-1");
    end
    if (MODE != FIFO_MODE_STD && MODE != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_sync_prog: MODE must be 0 or 1");
    end

    localparam logic [ADDRESSWIDTH:0] DEPTH_C = (ADDRESSWIDTH + 1)'(DEPTH);
    localparam logic [ADDRESSWIDTH:0] AF_C    = (ADDRESSWIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDRESSWIDTH:0] AE_C    = (ADDRESSWIDTH + 1)'(AEMPTY_THRESH);

    logic [ADDRESSWIDTH-1:0] wr_ptr;
    logic [ADDRESSWIDTH-1:0] rd_ptr;
    logic [ADDRESSWIDTH:0]   count_r;
    logic                    overflow_r;
    logic                    underflow_r;
    logic [DATAWIDTH-1:0]    ram_rdata;
    logic                    empty_w;
    logic                    full_w;
    logic                    wr_accept;
    logic                    rd_accept;

    assign empty_w   = (count_r == '0);
    assign full_w    = (count_r == DEPTH_C);
    assign wr_accept = write && !full_w && !flush;
    assign rd_accept = read && !empty_w && !flush;

    fifo_ram_sc #(
        .DATAWIDTH    (DATAWIDTH),
        .ADDRESSWIDTH (ADDRESSWIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, rd_accept})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            overflow_r  <= write && full_w;
            underflow_r <= read && empty_w;
        end
    end

    if (MODE == FIFO_MODE_STD) begin : g_std
        logic [DATAWIDTH-1:0] dout_r;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                dout_r <= '0;
            end else if (flush) begin
                dout_r <= '0;
            end else if (rd_accept) begin
                dout_r <= ram_rdata;
            end
        end

        assign dout = dout_r;
    end else begin : g_fwft
        // Head word is shown directly; forced to zero while empty so reset reads as 0.
        assign dout = empty_w ? '0 : ram_rdata;
    end

    assign empty        = empty_w;
    assign full         = full_w;
    assign almost_empty = (count_r <= AE_C);
    assign almost_full  = (count_r >= AF_C);
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: standard and FWFT instances driven in parallel, checked against a queue model.
module tb_fifo_sync_prog;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] din = '0;

    logic [7:0] dout_s, dout_f;
    logic       empty_s, full_s, ae_s, af_s, ovf_s, unf_s;
    logic       empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
    logic [4:0] count_s, count_f;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_prog #(.DATAWIDTH(8), .ADDRESSWIDTH(4), .MODE(0)) u_std (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write(write), .din(din), .read(read),
        .dout(dout_s), .empty(empty_s), .full(full_s), .almost_empty(ae_s), .almost_full(af_s),
        .count(count_s), .overflow(ovf_s), .underflow(unf_s)
    );

    fifo_sync_prog #(.DATAWIDTH(8), .ADDRESSWIDTH(4), .MODE(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write(write), .din(din), .read(read),
        .dout(dout_f), .empty(empty_f), .full(full_f), .almost_empty(ae_f), .almost_full(af_f),
        .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    // Reference: an unbounded word list addressed by head/tail counters, capacity 16.
    logic [7:0] m_buf [0:4095];
    int         m_head = 0;
    int         m_tail = 0;
    logic [7:0] m_dout = '0;
    logic       m_ovf  = 1'b0;
    logic       m_unf  = 1'b0;

    function automatic int m_size();
        return m_tail - m_head;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_head <= 0;
            m_tail <= 0;
            m_dout <= '0;
            m_ovf  <= 1'b0;
            m_unf  <= 1'b0;
        end else if (flush) begin
            m_head <= m_tail;
            m_dout <= '0;
            m_ovf  <= 1'b0;
            m_unf  <= 1'b0;
        end else begin
            if (write && m_size() < 16) begin
                m_buf[m_tail % 4096] <= din;
                m_tail <= m_tail + 1;
            end
            if (read && m_size() > 0) begin
                m_dout <= m_buf[m_head % 4096];
                m_head <= m_head + 1;
            end
            m_ovf <= write && (m_size() == 16);
            m_unf <= read && (m_size() == 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count_std", int'(count_s), m_size());
            chk("count_fwft", int'(count_f), m_size());
            chk("empty_std", int'(empty_s), int'(m_size() == 0));
            chk("empty_fwft", int'(empty_f), int'(m_size() == 0));
            chk("full_std", int'(full_s), int'(m_size() == 16));
            chk("full_fwft", int'(full_f), int'(m_size() == 16));
            chk("afull_std", int'(af_s), int'(m_size() >= 14));
            chk("aempty_std", int'(ae_s), int'(m_size() <= 2));
            chk("afull_fwft", int'(af_f), int'(m_size() >= 14));
            chk("aempty_fwft", int'(ae_f), int'(m_size() <= 2));
            chk("ovf_std", int'(ovf_s), int'(m_ovf));
            chk("unf_std", int'(unf_s), int'(m_unf));
            chk("ovf_fwft", int'(ovf_f), int'(m_ovf));
            chk("unf_fwft", int'(unf_f), int'(m_unf));
            chk("dout_std", int'(dout_s), int'(m_dout));
            if (m_size() > 0)
                chk("dout_fwft", int'(dout_f), int'(m_buf[m_head % 4096]));
            else if (!reset_n)
                chk("dout_fwft_rst", int'(dout_f), 0);
        end
    end

    // Inputs are applied at a falling edge and held across the next rising edge.
    task automatic drive(input logic w, input logic r, input logic f, input logic [7:0] d);
        write = w;
        read  = r;
        flush = f;
        din   = d;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_count", int'(count_s), 0);
        chk("rst_empty", int'(empty_s), 1);
        chk("rst_aempty", int'(ae_s), 1);
        chk("rst_dout", int'(dout_s), 0);
        reset_n = 1'b1;
        drive(0, 0, 0, 8'h00);

        // Fill with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 8'(i));
            if (i == 12) chk("afull_at13", int'(af_s), 0);
            if (i == 13) chk("afull_at14", int'(af_s), 1);
        end
        chk("fill_full", int'(full_s), 1);
        chk("fill_count", int'(count_s), 16);
        drive(1, 0, 0, 8'hEE);
        chk("ovf_pulse", int'(ovf_s), 1);
        chk("ovf_count", int'(count_s), 16);
        drive(0, 0, 0, 8'h00);
        chk("ovf_once", int'(ovf_s), 0);

        // Drain in MODE 0.
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 8'h00);
            chk("drain_dout", int'(dout_s), i);
        end
        chk("drain_empty", int'(empty_s), 1);
        drive(0, 1, 0, 8'h00);
        chk("unf_pulse", int'(unf_s), 1);
        chk("unf_dout_hold", int'(dout_s), 8'h0F);

        // First-word-fall-through.
        drive(1, 0, 0, 8'hA5);
        chk("fwft_nonempty", int'(empty_f), 0);
        chk("fwft_dout", int'(dout_f), 8'hA5);
        drive(0, 1, 0, 8'h00);
        chk("fwft_empty", int'(empty_f), 1);

        // Simultaneous read and write at full and at count 5.
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 8'($urandom));
        drive(1, 1, 0, 8'h77);
        chk("rw_full_count", int'(count_s), 15);
        chk("rw_full_ovf", int'(ovf_s), 1);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 8'h00);
        drive(1, 1, 0, 8'h3C);
        chk("rw_mid_count", int'(count_s), 5);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 8'h00);

        // Interleaved traffic crossing the pointer wrap.
        for (int i = 0; i < 40; i++) drive((i % 4) != 3, (i % 4) != 0, 0, 8'($urandom));

        // Flush with a concurrent write at count 9.
        drive(0, 0, 1, 8'h00);
        for (int i = 0; i < 9; i++) drive(1, 0, 0, 8'(8'h90 + i));
        chk("pre_flush_count", int'(count_s), 9);
        drive(1, 0, 1, 8'h99);
        chk("flush_count", int'(count_s), 0);
        chk("flush_empty", int'(empty_s), 1);
        chk("flush_dout", int'(dout_s), 0);
        drive(1, 0, 0, 8'h42);
        drive(0, 1, 0, 8'h00);
        chk("post_flush_dout", int'(dout_s), 8'h42);

        // Randomised traffic with shifting read/write bias and rare flushes.
        for (int blk = 0; blk < 8; blk++) begin
            int pw;
            pw = (blk % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 50; i++)
                drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (105 - pw),
                      $urandom_range(0, 99) < 2, 8'($urandom));
        end

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 6; i++) drive(1, 0, 0, 8'(8'hC0 + i));
        write = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", int'(count_s), 0);
        chk("arst_empty", int'(empty_s), 1);
        chk("arst_full", int'(full_s), 0);
        chk("arst_aempty", int'(ae_s), 1);
        chk("arst_afull", int'(af_s), 0);
        chk("arst_ovf", int'(ovf_s), 0);
        chk("arst_unf", int'(unf_s), 0);
        chk("arst_dout_std", int'(dout_s), 0);
        chk("arst_dout_fwft", int'(dout_f), 0);
        @(negedge clk);
        drive(1, 1, 0, 8'h11);
        drive(0, 0, 0, 8'h00);
        reset_n = 1'b1;
        drive(1, 0, 0, 8'h5A);
        chk("post_rst_count", int'(count_s), 1);
        drive(0, 1, 0, 8'h00);
        chk("post_rst_dout", int'(dout_s), 8'h5A);
        drive(0, 0, 0, 8'h00);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
